fp32_mul_seq: RTL

- Multi-cycle IEEE-754 binary32 multiplier; the complementary arithmetic unit to the Newton-iteration divider in the FP datapath.
- Uses the same operand/result conventions and start/enable/busy handshake as the divider, so the two are interchangeable behind one issue port.
- Mantissa product is formed iteratively by radix-2^RADIX_BITS shift-add.
- Special-value handling and result packing match the divider's IEEE rules.

---
 rtl/fp32_pkg.sv | 23 ++
 rtl/fp32_lzc24.sv | 14 +
 rtl/fp32_mul_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 constants, operand classes and sequencer states for the FP datapath units.
package fp32_pkg;

   localparam int          EXP_BIAS          = 127;
   localparam int          EXP_MAX           = 255;
   localparam logic [22:0] QNAN_DEFAULT_FRAC = 23'h400000;

   typedef enum logic [2:0] {ZERO, SUB, NORM, INF, NAN} fp_class_e;
   typedef enum logic [1:0] {IDLE, PREP, MUL, ROUND} state_e;

   // Sign is irrelevant to the class, so only the magnitude bits are taken.
   function automatic fp_class_e fp_classify(input logic [30:0] x);
      fp_class_e c;
      if (x[30:23] == 8'h00)
         c = (x[22:0] == 23'h0) ? ZERO : SUB;
      else if (x[30:23] == 8'hff)
         c = (x[22:0] == 23'h0) ? INF : NAN;
      else
         c = NORM;
      return c;
   endfunction

endpackage

// File: rtl/fp32_lzc24.sv
// Combinational 24-bit leading-zero counter; an all-zero input yields 24.
module fp32_lzc24 (
   input  logic [23:0] value,
   output logic [4:0]  count
);

   // Ascending scan: the highest set bit is the last one to write the count.
   always_comb begin
      count = 5'd24;
      for (int i = 0; i < 24; i++)
         if (value[i]) count = 5'(23 - i);
   end

endmodule

// File: rtl/fp32_mul_seq.sv
// Multi-cycle binary32 multiplier: radix-2^RADIX_BITS shift-add significand product, RNE rounding.
// Define FP32_MUL_FTZ_EN to flush subnormal operands and results to signed zero.
module fp32_mul_seq
   import fp32_pkg::*;
#(
   parameter int RADIX_BITS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        start,
   input  logic [31:0] input_a,
   input  logic [31:0] input_b,
   output logic [31:0] output_z,
   output logic        busy,
   output logic        done
);

   localparam int                ITER = 24 / RADIX_BITS;
   localparam logic signed [9:0] BIAS = 10'(EXP_BIAS);
   localparam logic signed [9:0] EMAX = 10'(EXP_MAX);

   state_e            state, state_n;
   logic [31:0]       a_q, a_n, b_q, b_n;
   logic              sign_q, sign_n;
   logic signed [9:0] exp_q, exp_n;
   logic [47:0]       mcand_q, mcand_n, acc_q, acc_n;
   logic [23:0]       mplier_q, mplier_n;
   logic [4:0]        cnt_q, cnt_n;
   logic              spec_q, spec_n;
   logic [31:0]       spec_val_q, spec_val_n;
   logic [31:0]       z_n;
   logic              busy_n, done_n;

   fp_class_e         cls_a, cls_b;
   logic [23:0]       sig_a, sig_b;
   logic signed [9:0] ea, eb;
   logic              prep_sign, prep_spec;
   logic [31:0]       prep_val;

   logic signed [9:0] e_adj;
   logic [24:0]       ext, ext_sh;
   logic              sticky, rup;
   logic [7:0]        efield;
   logic [30:0]       mag;
   logic [31:0]       rounded;

`ifdef FP32_MUL_FTZ_EN
   always_comb begin
      cls_a = fp_classify(a_q[30:0]);
      cls_b = fp_classify(b_q[30:0]);
      if (cls_a == SUB) cls_a = ZERO;
      if (cls_b == SUB) cls_b = ZERO;
      sig_a = {1'b1, a_q[22:0]};
      sig_b = {1'b1, b_q[22:0]};
      ea    = $signed({2'b00, a_q[30:23]});
      eb    = $signed({2'b00, b_q[30:23]});
   end
`else
   logic [23:0] raw_a, raw_b;
   logic [4:0]  lzc_a, lzc_b;

   assign raw_a = {a_q[30:23] != 8'h00, a_q[22:0]};
   assign raw_b = {b_q[30:23] != 8'h00, b_q[22:0]};

   fp32_lzc24 u_lzc_a (.value(raw_a), .count(lzc_a));
   fp32_lzc24 u_lzc_b (.value(raw_b), .count(lzc_b));

   // Subnormals are shifted up to a leading one and carry exponent 1 - lzc instead.
   always_comb begin
      cls_a = fp_classify(a_q[30:0]);
      cls_b = fp_classify(b_q[30:0]);
      sig_a = raw_a << lzc_a;
      sig_b = raw_b << lzc_b;
      ea    = (a_q[30:23] == 8'h00) ? $signed(10'd1 - {5'd0, lzc_a}) : $signed({2'b00, a_q[30:23]});
      eb    = (b_q[30:23] == 8'h00) ? $signed(10'd1 - {5'd0, lzc_b}) : $signed({2'b00, b_q[30:23]});
   end
`endif

   always_comb begin
      prep_sign = a_q[31] ^ b_q[31];
      prep_spec = 1'b1;
      prep_val  = {prep_sign, 31'h0};
      if (cls_a == NAN)
         prep_val = {prep_sign, 8'hff, 1'b1, a_q[21:0]};
      else if (cls_b == NAN)
         prep_val = {prep_sign, 8'hff, 1'b1, b_q[21:0]};
      else if ((cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF))
         prep_val = {prep_sign, 8'hff, QNAN_DEFAULT_FRAC};
      else if (cls_a == INF || cls_b == INF)
         prep_val = {prep_sign, 8'hff, 23'h0};
      else if (cls_a == ZERO || cls_b == ZERO)
         prep_val = {prep_sign, 31'h0};
      else
         prep_spec = 1'b0;
   end

`ifndef FP32_MUL_FTZ_EN
   logic [4:0]  sh;
   logic [25:0] lost_mask;

   assign sh        = (e_adj < -10'sd24) ? 5'd26 : 5'(10'sd1 - e_adj);
   assign lost_mask = (26'd1 << sh) - 26'd1;
`endif

   // ext holds {fraction, guard, round}; the leading one is implicit for any non-special product.
   always_comb begin
      if (acc_q[47]) begin
         e_adj  = exp_q + 10'sd1;
         ext    = acc_q[46:22];
         sticky = |acc_q[21:0];
      end else begin
         e_adj  = exp_q;
         ext    = acc_q[45:21];
         sticky = |acc_q[20:0];
      end
      ext_sh = ext;
      efield = e_adj[7:0];
`ifndef FP32_MUL_FTZ_EN
      if (e_adj <= 10'sd0) begin
         ext_sh = 25'({1'b1, ext} >> sh);
         sticky = sticky | (|({1'b1, ext} & lost_mask));
         efield = 8'h00;
      end
`endif
      rup = ext_sh[1] & (ext_sh[0] | sticky | ext_sh[2]);
      mag = {efield, ext_sh[24:2]} + {30'h0, rup};
      if (e_adj >= EMAX)
         rounded = {sign_q, 8'hff, 23'h0};
`ifdef FP32_MUL_FTZ_EN
      else if (e_adj <= 10'sd0)
         rounded = {sign_q, 31'h0};
`endif
      else
         rounded = {sign_q, mag};
   end

   always_comb begin
      state_n    = state;
      a_n        = a_q;
      b_n        = b_q;
      sign_n     = sign_q;
      exp_n      = exp_q;
      mcand_n    = mcand_q;
      mplier_n   = mplier_q;
      acc_n      = acc_q;
      cnt_n      = cnt_q;
      spec_n     = spec_q;
      spec_val_n = spec_val_q;
      z_n        = output_z;
      busy_n     = busy;
      done_n     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               a_n     = input_a;
               b_n     = input_b;
               busy_n  = 1'b1;
               state_n = PREP;
            end
         end
         PREP: begin
            sign_n     = prep_sign;
            exp_n      = ea + eb - BIAS;
            mcand_n    = {24'h0, sig_a};
            mplier_n   = sig_b;
            acc_n      = 48'h0;
            cnt_n      = 5'(ITER);
            spec_n     = prep_spec;
            spec_val_n = prep_val;
            state_n    = MUL;
         end
         MUL: begin
            acc_n    = acc_q + mcand_q * 48'(mplier_q[RADIX_BITS-1:0]);
            mcand_n  = mcand_q << RADIX_BITS;
            mplier_n = mplier_q >> RADIX_BITS;
            cnt_n    = cnt_q - 5'd1;
            if (cnt_q == 5'd1) state_n = ROUND;
         end
         ROUND: begin
            z_n     = spec_q ? spec_val_q : rounded;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // enable low freezes every register, which also stretches a pending done pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         a_q        <= 32'h0;
         b_q        <= 32'h0;
         sign_q     <= 1'b0;
         exp_q      <= 10'sd0;
         mcand_q    <= 48'h0;
         mplier_q   <= 24'h0;
         acc_q      <= 48'h0;
         cnt_q      <= 5'd0;
         spec_q     <= 1'b0;
         spec_val_q <= 32'h0;
         output_z   <= 32'h0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else if (enable) begin
         state      <= state_n;
         a_q        <= a_n;
         b_q        <= b_n;
         sign_q     <= sign_n;
         exp_q      <= exp_n;
         mcand_q    <= mcand_n;
         mplier_q   <= mplier_n;
         acc_q      <= acc_n;
         cnt_q      <= cnt_n;
         spec_q     <= spec_n;
         spec_val_q <= spec_val_n;
         output_z   <= z_n;
         busy       <= busy_n;
         done       <= done_n;
      end
   end

endmodule
